irq_ctl: RTL and testbench

Parametrised interrupt controller for the Beta processor. It sits between external interrupt sources and the control unit. It synchronises up to NUM_IRQ request lines and latches them as edge- or level-pending. It applies a software-writable mask and picks the highest-priority enabled request. That request goes to the control unit over a req/ack handshake, gated by the supervisor bit, and the controller tracks the service period until return-from-interrupt.

---
 rtl/irq_ctl.sv | 154 +++++++++++++++
 tb/tb_irq_ctl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctl.sv
// Interrupt controller: synchronises request lines, latches edge/level pending, masks, fixed-priority select, req/ack/done service tracking.
// Latency: edge source -> irq_req 4 cycles, level source -> irq_req 3 cycles (from first sampling edge, FSM idle, channel enabled).
// Backpressure: irq_req is held with a stable irq_vec until irq_ack; sv_bit or a vanished request withdraws it, pending is kept.
module irq_ctl #(
    parameter int                 NUM_IRQ   = 8,
    parameter logic [NUM_IRQ-1:0] EDGE_MODE = '0,
    localparam int                VEC_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic [NUM_IRQ-1:0] mask,
    output logic [NUM_IRQ-1:0] pending,
    input  logic               sv_bit,
    output logic               irq_req,
    output logic [VEC_W-1:0]   irq_vec,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    localparam logic [NUM_IRQ-1:0] ONE = NUM_IRQ'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [VEC_W-1:0]   r_vec;
    logic [VEC_W-1:0]   w_vec_nxt;

    logic [NUM_IRQ-1:0] r_s1;
    logic [NUM_IRQ-1:0] r_s2;
    logic [NUM_IRQ-1:0] r_s2_d;
    logic [NUM_IRQ-1:0] r_edge_pend;
    logic [NUM_IRQ-1:0] r_mask;

    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [NUM_IRQ-1:0] w_cur_sel;
    logic [NUM_IRQ-1:0] w_ack_clr;
    logic               w_ack_take;
    logic               w_cur_elig;
    logic               w_any;
    logic [VEC_W-1:0]   w_win;

    // Rising edge seen at the synchroniser output; only meaningful for edge channels.
    assign w_rise     = r_s2 & ~r_s2_d;

    // Edge channels read the latch, level channels follow the synchronised source directly.
    assign w_pending  = (r_edge_pend & EDGE_MODE) | (r_s2 & ~EDGE_MODE);
    assign w_eligible = w_pending & r_mask;

    // An accepted ack clears only the edge latch of the channel being requested.
    assign w_ack_take = (r_state == S_REQ) && irq_ack;
    assign w_cur_sel  = ONE << r_vec;
    assign w_ack_clr  = w_ack_take ? w_cur_sel : '0;
    assign w_cur_elig = |(w_eligible & w_cur_sel);
    assign w_any      = |w_eligible;

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s2_d <= '0;
        end else begin
            r_s1   <= irq_in;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    // Edge latches: a new edge beats a simultaneous ack clear; recorded regardless of mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge_pend <= '0;
        end else begin
            r_edge_pend <= ((r_edge_pend & ~w_ack_clr) | w_rise) & EDGE_MODE;
        end
    end

    // Software mask register; a write only influences selection from the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
        end else if (mask_we) begin
            r_mask <= mask_wdata;
        end
    end

    // Fixed priority: lowest eligible index wins (scan downward so the lowest is written last).
    always_comb begin
        w_win = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_win = VEC_W'(i);
            end
        end
    end

    // FSM state and latched vector register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
        end
    end

    // FSM next state: ack beats withdrawal in REQ; ack/done outside their states are ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        case (r_state)
            S_IDLE: begin
                if (w_any && !sv_bit) begin
                    w_state_nxt = S_REQ;
                    w_vec_nxt   = w_win;
                end
            end
            S_REQ: begin
                if (irq_ack) begin
                    w_state_nxt = S_SERVICE;
                end else if (sv_bit || !w_cur_elig) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (irq_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign irq_req = (r_state == S_REQ);
    assign busy    = (r_state == S_SERVICE);
    assign irq_vec = r_vec;
    assign mask    = r_mask;
    assign pending = w_pending;

endmodule

// File: tb/tb_irq_ctl.sv
// Bench for irq_ctl: directed stimulus pushes expected (vector, cycle) per request into a scoreboard.
// A negedge monitor pops and compares on every rising irq_req; stimulus also checks pending/busy/mask directly.
// All waits are fixed cycle counts, so the run always terminates.
module tb_irq_ctl;

    localparam int                 N    = 8;
    localparam logic [N-1:0]       EDGE = 8'hFD;   // channel 1 level, all others edge

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_in;
    logic         mask_we;
    logic [N-1:0] mask_wdata;
    logic [N-1:0] mask;
    logic [N-1:0] pending;
    logic         sv_bit;
    logic         irq_req;
    logic [2:0]   irq_vec;
    logic         irq_ack;
    logic         irq_done;
    logic         busy;

    irq_ctl #(.NUM_IRQ(N), .EDGE_MODE(EDGE)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .pending    (pending),
        .sv_bit     (sv_bit),
        .irq_req    (irq_req),
        .irq_vec    (irq_vec),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int vec;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int v, input int c);
        exp_t e;
        e.vec = v;
        e.cyc = c;
        sb_q.push_back(e);
    endtask

    // Monitor: every new request must match the oldest expected entry in vector and arrival cycle.
    always @(negedge clk) begin
        if (irq_req === 1'b1 && prev_req !== 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_req", {29'd0, irq_vec}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("req_vec", {29'd0, irq_vec}, e.vec);
                chk("req_cycle", cyc, e.cyc);
            end
        end
        prev_req = irq_req;
    end

    initial begin
        int c;
        reset      = 1'b1;
        irq_in     = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        sv_bit     = 1'b0;
        irq_ack    = 1'b0;
        irq_done   = 1'b0;

        // Reset state
        tick(2);
        chk("rst_mask", mask, 0);
        chk("rst_pending", pending, 0);
        chk("rst_req", irq_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vec", irq_vec, 0);
        reset = 1'b0;
        tick(1);

        // Enable all channels
        mask_we = 1'b1; mask_wdata = 8'hFF;
        tick(1);
        mask_we = 1'b0;
        chk("mask_ff", mask, 8'hFF);

        // Edge pulse on channel 3: request 4 cycles later
        c = cyc; push(3, c + 4);
        irq_in[3] = 1'b1; tick(1); irq_in[3] = 1'b0; tick(3);
        chk("t1_req", irq_req, 1);
        chk("t1_pend3", pending[3], 1);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        chk("t1_pend3_clr", pending[3], 0);
        chk("t1_busy", busy, 1);
        chk("t1_req_low", irq_req, 0);
        irq_done = 1'b1; tick(1); irq_done = 1'b0;
        chk("t1_done", busy, 0);
        tick(2);

        // Channels 5 and 2 together: 2 first, then 5
        c = cyc; push(2, c + 4);
        irq_in = 8'h24; tick(1); irq_in = '0; tick(3);
        chk("t2_pend", pending, 8'h24);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        chk("t2_pend_after_ack", pending, 8'h20);
        c = cyc; push(5, c + 2);
        irq_done = 1'b1; tick(1); irq_done = 1'b0;
        chk("t2_busy_off", busy, 0);
        tick(1);
        chk("t2_req5", irq_req, 1);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        irq_done = 1'b1; tick(1); irq_done = 1'b0;
        tick(2);
        chk("t2_pend_empty", pending, 0);

        // Level channel 1 held across ack and done
        c = cyc; push(1, c + 3);
        irq_in[1] = 1'b1; tick(3);
        chk("t3_req", irq_req, 1);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        chk("t3_pend1_kept", pending[1], 1);
        c = cyc; push(1, c + 2);
        irq_done = 1'b1; tick(1); irq_done = 1'b0;
        tick(1);
        chk("t3_rereq", irq_req, 1);
        irq_in[1] = 1'b0; irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        tick(1);
        chk("t3_pend1_gone", pending[1], 0);
        irq_done = 1'b1; tick(1); irq_done = 1'b0;
        tick(4);
        chk("t3_no_req", irq_req, 0);

        // Supervisor bit blocks and withdraws
        sv_bit = 1'b1;
        irq_in[0] = 1'b1; tick(1); irq_in[0] = 1'b0; tick(5);
        chk("t4_pend0", pending[0], 1);
        chk("t4_blocked", irq_req, 0);
        c = cyc; push(0, c + 1);
        sv_bit = 1'b0; tick(1);
        chk("t4_req", irq_req, 1);
        sv_bit = 1'b1; tick(1);
        chk("t4_withdrawn", irq_req, 0);
        chk("t4_pend0_kept", pending[0], 1);
        c = cyc; push(0, c + 1);
        sv_bit = 1'b0; tick(1);
        chk("t4_rereq", irq_req, 1);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        irq_done = 1'b1; tick(1); irq_done = 1'b0;
        tick(2);

        // Masked channel 4 stays pending until enabled
        mask_we = 1'b1; mask_wdata = 8'h00; tick(1); mask_we = 1'b0;
        irq_in[4] = 1'b1; tick(1); irq_in[4] = 1'b0; tick(5);
        chk("t5_pend4", pending[4], 1);
        chk("t5_masked", irq_req, 0);
        c = cyc; push(4, c + 2);
        mask_we = 1'b1; mask_wdata = 8'h10; tick(1); mask_we = 1'b0;
        tick(1);
        chk("t5_req", irq_req, 1);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        irq_done = 1'b1; tick(1); irq_done = 1'b0;
        mask_we = 1'b1; mask_wdata = 8'hFF; tick(1); mask_we = 1'b0;
        tick(2);

        // New edge on channel 6 coinciding with its ack, then reset in service
        c = cyc; push(6, c + 4);
        irq_in[6] = 1'b1; tick(1); irq_in[6] = 1'b0; tick(3);
        irq_in[6] = 1'b1; tick(1); irq_in[6] = 1'b0; tick(1);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        chk("t6_busy", busy, 1);
        chk("t6_pend6_set_wins", pending[6], 1);
        reset = 1'b1; tick(1);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_mask", mask, 0);
        chk("t6_rst_pending", pending, 0);
        chk("t6_rst_req", irq_req, 0);
        chk("t6_rst_vec", irq_vec, 0);
        reset = 1'b0;
        tick(5);

        chk("sb_leftover", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
